// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler in front of one iterative shift-add multiplier shared by 2**ID_W requesters.
// Optional macro MUL_EARLY_EXIT_EN ends the BUSY phase as soon as no multiplier bits remain.
module mul_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(1<<ID_W)-1:0]          req_valid,
  output logic [(1<<ID_W)-1:0]          req_ready,
  input  logic [(1<<ID_W)*WIDTH-1:0]    req_a,
  input  logic [(1<<ID_W)*WIDTH-1:0]    req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*WIDTH-1:0]            rsp_prod,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int NREQ  = 1 << ID_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      r_last;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [2*WIDTH-1:0]   r_rsp_prod;
  logic                 r_busy;

  logic [ID_W-1:0]      w_grant;
  logic                 w_grant_vld;
  logic [WIDTH-1:0]     w_a_sel;
  logic [WIDTH-1:0]     w_b_sel;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_b_next;
  logic                 w_last_bit;

  // Search downward from last_grant+NREQ so the closest successor of last_grant wins.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[ID_W'(r_last + ID_W'(k))]) begin
        w_grant     = ID_W'(r_last + ID_W'(k));
        w_grant_vld = 1'b1;
      end
    end
  end

  // Handshake: a request is taken on the edge where req_valid[i] & req_ready[i];
  // req_ready is a one-hot (or zero) grant, raised only in IDLE.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_grant_vld) req_ready[w_grant] = 1'b1;
  end

  assign w_a_sel    = req_a[int'(w_grant)*WIDTH +: WIDTH];
  assign w_b_sel    = req_b[int'(w_grant)*WIDTH +: WIDTH];
  assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);
  assign w_b_next   = r_b_sh >> 1;

  always_comb begin
`ifdef MUL_EARLY_EXIT_EN
    w_last_bit = (w_b_next == '0) || (r_cnt == CNT_W'(WIDTH - 1));
`else
    w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(NREQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_a_sh  <= {{WIDTH{1'b0}}, w_a_sel};
            r_b_sh  <= w_b_sel;
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= w_b_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_bit) begin
            r_rsp_prod  <= w_acc_next;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_prod  = r_rsp_prod;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler: reset, latency, round robin, backpressure, mid-BUSY reset.
module tb_mul_rr_scheduler;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_prod;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  mul_rr_scheduler #(.WIDTH(16), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int early_lat);
    return EARLY ? early_lat : 16;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one request, waits (bounded) for its grant and completes the handshake.
  task automatic send(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] prod);
    int n;
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 100) begin
      tick();
      n++;
    end
    chk("grant", 64'(req_ready), 64'(4'b1 << id));
    tick();
    req_valid[id] = 1'b0;
    exp_q.push_back({id[1:0], prod});
  endtask

  // Waits for rsp_valid, checks latency and contents against the scoreboard head.
  task automatic wait_rsp(input int exp_lat);
    int l;
    logic [33:0] e;
    l = 0;
    while (!rsp_valid && l < 100) begin
      tick();
      l++;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(l), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    chk("rsp_id", 64'(rsp_id), 64'(e[33:32]));
    chk("rsp_prod", 64'(rsp_prod), 64'(e[31:0]));
    chk("no_grant_in_done", 64'(req_ready), 64'd0);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("idle_after_accept", 64'(dbg_state), 64'd0);
  endtask

  logic [15:0] rr_a [4] = '{16'h0011, 16'h0100, 16'h1234, 16'h00FF};
  logic [15:0] rr_b [4] = '{16'h0002, 16'h0100, 16'h0010, 16'h0101};
  logic [31:0] rr_p [4] = '{32'h0000_0022, 32'h0001_0000, 32'h0001_2340, 32'h0000_FFFF};

  initial begin
    int n;
    int seen;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset();

    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);

    send(0, 16'h0020, 16'h0026, 32'h0000_04C0);
    chk("busy_in_busy", 64'(busy), 64'd1);
    chk("state_busy", 64'(dbg_state), 64'd1);
    wait_rsp(lat(6));
    accept();

    send(2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    wait_rsp(lat(16));
    accept();

    send(0, 16'h1234, 16'h0001, 32'h0000_1234);
    wait_rsp(lat(1));
    accept();
    send(1, 16'hABCD, 16'h0000, 32'h0000_0000);
    wait_rsp(lat(1));
    accept();
    send(3, 16'h0000, 16'h8000, 32'h0000_0000);
    wait_rsp(lat(16));
    accept();

    // Round robin from reset: all four held valid, consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = rr_a[i];
      req_b[i*16 +: 16] = rr_b[i];
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (req_ready == '0 && n < 50) begin
        tick();
        n++;
      end
      chk("rr_grant", 64'(req_ready), 64'(4'b1 << (r % 4)));
      tick();
      if (r == 4) req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 50) begin
        tick();
        n++;
      end
      chk("rr_rsp_id", 64'(rsp_id), 64'(r % 4));
      chk("rr_rsp_prod", 64'(rsp_prod), 64'(rr_p[r % 4]));
      tick();
    end
    rsp_ready = 1'b0;
    chk("rr_end_idle", 64'(rsp_valid), 64'd0);

    // Backpressure for 20 cycles with another requester waiting.
    send(1, 16'h0003, 16'h0005, 32'h0000_000F);
    wait_rsp(lat(3));
    req_a[15:0] = 16'h0002;
    req_b[15:0] = 16'h0002;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_prod", 64'(rsp_prod), 64'h0000_000F);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid[0] = 1'b0;
    accept();
    seen = 0;
    repeat (5) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("bp_single_transfer", 64'(seen), 64'd0);

    // Reset in the middle of BUSY discards the pending product.
    send(3, 16'h0007, 16'h8009, 32'h0003_803F);
    repeat (7) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_prod", 64'(rsp_prod), 64'd0);
    chk("async_rst_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);

    req_a[31:16] = 16'h0010;
    req_b[31:16] = 16'h0010;
    req_valid[1] = 1'b1;
    send(0, 16'h0007, 16'h0009, 32'h0000_003F);
    wait_rsp(lat(4));
    accept();
    req_valid[1] = 1'b0;
    send(1, 16'h0010, 16'h0010, 32'h0000_0100);
    wait_rsp(lat(5));
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
